i2c_reg_peripheral: RTL and testbench



---
 rtl/i2c_reg_peripheral_pkg.sv | 26 ++
 rtl/i2c_bus_sync.sv | 42 ++++
 rtl/i2c_reg_peripheral.sv | 161 ++++++++++++++++
 tb/tb_i2c_reg_peripheral.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_reg_peripheral_pkg.sv
// Shared types and constants for the I2C register-bridge target.
package i2c_reg_peripheral_pkg;

  localparam int BYTE_W = 8;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } state_t;

  function automatic logic [BYTE_W-1:0] addr_inc(input logic [BYTE_W-1:0] addr);
    return addr + 8'd1;
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronizers for SCL/SDA plus edge and START/STOP strobes.
module i2c_bus_sync (
  input  logic sys_clk,
  input  logic rst,
  input  logic scl_pin,
  input  logic sda_pin,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic scl_p0, scl_p1, scl_p2;
  logic sda_p0, sda_p1, sda_p2;

  // _p0/_p1 synchronize, _p2 holds the previous synchronized value
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      scl_p0 <= 1'b1;
      scl_p1 <= 1'b1;
      scl_p2 <= 1'b1;
      sda_p0 <= 1'b1;
      sda_p1 <= 1'b1;
      sda_p2 <= 1'b1;
    end else begin
      scl_p0 <= scl_pin;
      scl_p1 <= scl_p0;
      scl_p2 <= scl_p1;
      sda_p0 <= sda_pin;
      sda_p1 <= sda_p0;
      sda_p2 <= sda_p1;
    end
  end

  assign sda      = sda_p1;
  assign scl_rise = scl_p1 & ~scl_p2;
  assign scl_fall = ~scl_p1 & scl_p2;
  assign start    = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
  assign stop     = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;

endmodule

// File: rtl/i2c_reg_peripheral.sv
// I2C target bridging 7-bit bus transfers to a byte-wide register handshake
// interface with auto-incrementing register address.
module i2c_reg_peripheral
  import i2c_reg_peripheral_pkg::*;
#(
  parameter logic [6:0] I2C_PERIPHERAL_ADDRESS = 7'h33
) (
  input  logic              i_sys_clk,
  input  logic              i_rst,
  inout  wire               io_scl,
  inout  wire               io_sda,
  output logic [BYTE_W-1:0] o_register_address,
  output logic              o_read_enable,
  input  logic [BYTE_W-1:0] i_register_data,
  input  logic              i_read_valid,
  output logic              o_read_ack,
  output logic [BYTE_W-1:0] o_register_data,
  output logic              o_write_valid,
  input  logic              i_write_ack
);

  logic sda_s, scl_rise, scl_fall, bus_start, bus_stop;

  i2c_bus_sync u_sync (
    .sys_clk  (i_sys_clk),
    .rst      (i_rst),
    .scl_pin  (io_scl),
    .sda_pin  (io_sda),
    .sda      (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (bus_start),
    .stop     (bus_stop)
  );

  state_t            state;
  logic [2:0]        bit_cnt;
  logic              ack_ph;
  logic              sda_low;
  logic [BYTE_W-1:0] shift_rx, shift_tx, hold_data;
  logic [BYTE_W-1:0] rx_byte, tx_src;
  logic              rd_dir;

  assign rx_byte    = {shift_rx[BYTE_W-2:0], sda_s};
  assign o_read_ack = o_read_enable & i_read_valid;
  assign tx_src     = o_read_ack ? i_register_data : hold_data;
  assign rd_dir     = (shift_rx[0] == RW_READ);
  assign io_sda     = sda_low ? 1'b0 : 1'bz;

  // ack_ph: 0 = waiting for the SCL fall that ends bit 8, 1 = inside the ACK bit
  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      state              <= ST_IDLE;
      bit_cnt            <= 3'd0;
      ack_ph             <= 1'b0;
      sda_low            <= 1'b0;
      shift_rx           <= '0;
      shift_tx           <= '0;
      hold_data          <= '0;
      o_register_address <= '0;
      o_register_data    <= '0;
      o_write_valid      <= 1'b0;
      o_read_enable      <= 1'b0;
    end else begin
      if (o_read_ack)
        hold_data <= i_register_data;
      if (o_write_valid && i_write_ack) begin
        o_write_valid      <= 1'b0;
        o_register_address <= addr_inc(o_register_address);
      end
      if (bus_start || bus_stop) begin
        state         <= bus_start ? ST_ADDR : ST_IDLE;
        bit_cnt       <= 3'd0;
        ack_ph        <= 1'b0;
        sda_low       <= 1'b0;
        o_write_valid <= 1'b0;
        o_read_enable <= 1'b0;
      end else begin
        case (state)
          ST_ADDR, ST_REG, ST_WR_DATA: begin
            if (scl_rise) begin
              shift_rx <= rx_byte;
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                ack_ph <= 1'b0;
                if (state == ST_ADDR) begin
                  state <= (rx_byte[7:1] == I2C_PERIPHERAL_ADDRESS) ? ST_ADDR_ACK : ST_IGNORE;
                end else if (state == ST_REG) begin
                  o_register_address <= rx_byte;
                  state              <= ST_REG_ACK;
                end else begin
                  o_register_data <= rx_byte;
                  o_write_valid   <= 1'b1;
                  state           <= ST_WR_ACK;
                end
              end
            end
          end
          ST_ADDR_ACK, ST_REG_ACK, ST_WR_ACK: begin
            if (scl_fall) begin
              if (!ack_ph) begin
                sda_low <= 1'b1;
                ack_ph  <= 1'b1;
              end else begin
                ack_ph  <= 1'b0;
                bit_cnt <= 3'd0;
                if (state == ST_ADDR_ACK && rd_dir) begin
                  o_read_enable <= 1'b0;
                  shift_tx      <= {tx_src[BYTE_W-2:0], 1'b0};
                  sda_low       <= ~tx_src[BYTE_W-1];
                  state         <= ST_RD_DATA;
                end else begin
                  sda_low <= 1'b0;
                  state   <= (state == ST_ADDR_ACK && shift_rx[0] == RW_WRITE) ? ST_REG : ST_WR_DATA;
                end
              end
            end else if (scl_rise && ack_ph && state == ST_ADDR_ACK && rd_dir) begin
              o_read_enable <= 1'b1;
            end
          end
          ST_RD_DATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                ack_ph <= 1'b0;
                state  <= ST_RD_ACK;
              end
            end else if (scl_fall) begin
              sda_low  <= ~shift_tx[BYTE_W-1];
              shift_tx <= {shift_tx[BYTE_W-2:0], 1'b0};
            end
          end
          ST_RD_ACK: begin
            if (scl_fall) begin
              if (!ack_ph) begin
                sda_low <= 1'b0;
                ack_ph  <= 1'b1;
              end else begin
                o_read_enable <= 1'b0;
                ack_ph        <= 1'b0;
                bit_cnt       <= 3'd0;
                shift_tx      <= {tx_src[BYTE_W-2:0], 1'b0};
                sda_low       <= ~tx_src[BYTE_W-1];
                state         <= ST_RD_DATA;
              end
            end else if (scl_rise && ack_ph) begin
              if (!sda_s) begin
                o_read_enable      <= 1'b1;
                o_register_address <= addr_inc(o_register_address);
              end else begin
                state <= ST_IGNORE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_peripheral.sv
// Bench for i2c_reg_peripheral: bit-banged I2C master, register-file responder
// and a byte-level memory model of the expected register contents.
module tb_i2c_reg_peripheral;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m, sda_m_low;
  wire        scl_w, sda_w;
  logic [7:0] o_register_address, o_register_data, i_register_data;
  logic       o_read_enable, i_read_valid, o_read_ack, o_write_valid, i_write_ack;

  initial forever #5 clk = ~clk;

  assign scl_w = scl_m;
  assign sda_w = sda_m_low ? 1'b0 : 1'bz;
  pullup (sda_w);

  i2c_reg_peripheral #(.I2C_PERIPHERAL_ADDRESS(7'h33)) dut (
    .i_sys_clk          (clk),
    .i_rst              (rst),
    .io_scl             (scl_w),
    .io_sda             (sda_w),
    .o_register_address (o_register_address),
    .o_read_enable      (o_read_enable),
    .i_register_data    (i_register_data),
    .i_read_valid       (i_read_valid),
    .o_read_ack         (o_read_ack),
    .o_register_data    (o_register_data),
    .o_write_valid      (o_write_valid),
    .i_write_ack        (i_write_ack)
  );

  // Register-file side (owned by the responder process)
  logic [7:0]  rf_mem [256];
  logic [15:0] wr_log [$];
  logic [7:0]  rd_addr_log [$];
  int          wv_cycles, re_cycles, rack_cycles, ack_done_cnt;
  // Test-side state
  bit          auto_ack;
  int          ack_req_cnt;
  logic [7:0]  model_mem [256];
  int          n_checks, n_fail;

  initial begin
    int ack_dly;
    bit re_prev;
    i_write_ack = 1'b0; i_read_valid = 1'b0; i_register_data = 8'h00;
    ack_dly = 0; re_prev = 1'b0; ack_done_cnt = 0;
    wv_cycles = 0; re_cycles = 0; rack_cycles = 0;
    for (int i = 0; i < 256; i++) rf_mem[i] = 8'h00;
    rf_mem[8'h10] = 8'hEF; rf_mem[8'h11] = 8'hBE; rf_mem[8'h12] = 8'hAD; rf_mem[8'h13] = 8'hDE;
    rf_mem[8'hAA] = 8'h55;
    forever begin
      @(negedge clk);
      if (o_write_valid) wv_cycles++;
      if (o_read_enable) re_cycles++;
      if (o_read_ack) rack_cycles++;
      if (o_read_enable && !re_prev) rd_addr_log.push_back(o_register_address);
      re_prev = o_read_enable;
      i_read_valid = o_read_enable;
      i_register_data = rf_mem[o_register_address];
      if (i_write_ack) begin
        i_write_ack = 1'b0;
      end else if (o_write_valid && (auto_ack || ack_done_cnt < ack_req_cnt)) begin
        if (ack_dly > 0) begin
          ack_dly--;
        end else begin
          i_write_ack = 1'b1;
          rf_mem[o_register_address] = o_register_data;
          wr_log.push_back({o_register_address, o_register_data});
          if (!auto_ack) ack_done_cnt++;
          ack_dly = $urandom_range(0, 3);
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m_low = 1'b0; wait_clk(Q);
    scl_m = 1'b1;     wait_clk(Q);
    sda_m_low = 1'b1; wait_clk(Q);
    scl_m = 1'b0;     wait_clk(Q);
  endtask

  task automatic bus_stop();
    sda_m_low = 1'b1; wait_clk(Q);
    scl_m = 1'b1;     wait_clk(Q);
    sda_m_low = 1'b0; wait_clk(Q);
  endtask

  task automatic send_bit(input logic b);
    sda_m_low = ~b; wait_clk(Q);
    scl_m = 1'b1;   wait_clk(2*Q);
    scl_m = 1'b0;   wait_clk(Q);
  endtask

  task automatic recv_bit(output logic b, output logic re_hi);
    sda_m_low = 1'b0; wait_clk(Q);
    scl_m = 1'b1;     wait_clk(Q);
    b = (sda_w === 1'b0) ? 1'b0 : 1'b1;
    wait_clk(Q);
    re_hi = o_read_enable;
    scl_m = 1'b0;     wait_clk(Q);
  endtask

  task automatic send_bits(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic nack);
    logic re;
    send_bits(d);
    recv_bit(nack, re);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic master_ack);
    logic bb, re;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(bb, re);
      d[i] = bb;
    end
    send_bit(~master_ack);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(2);
    n_checks++; if (o_register_address !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h want 00", o_register_address); end
    n_checks++; if (o_register_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", o_register_data); end
    n_checks++; if (o_write_valid !== 1'b0 || o_read_enable !== 1'b0 || o_read_ack !== 1'b0) begin
      n_fail++; $display("FAIL reset_strobes: wv=%b re=%b rack=%b want 000", o_write_valid, o_read_enable, o_read_ack); end
    n_checks++; if (sda_w === 1'b0) begin n_fail++; $display("FAIL reset_sda: SDA held low, want released"); end
  endtask

  task automatic test_write_single();
    logic nack, re;
    auto_ack = 1'b0;
    bus_start();
    send_byte(8'h66, nack);
    n_checks++; if (nack !== 1'b0) begin n_fail++; $display("FAIL ws_addr_ack: got %b want 0", nack); end
    send_byte(8'h55, nack);
    n_checks++; if (nack !== 1'b0) begin n_fail++; $display("FAIL ws_reg_ack: got %b want 0", nack); end
    send_bits(8'hAA);
    wait_clk(2);
    n_checks++; if (o_register_address !== 8'h55) begin n_fail++; $display("FAIL ws_addr: got %h want 55", o_register_address); end
    n_checks++; if (o_register_data !== 8'hAA) begin n_fail++; $display("FAIL ws_data: got %h want AA", o_register_data); end
    n_checks++; if (o_write_valid !== 1'b1) begin n_fail++; $display("FAIL ws_valid: got %b want 1", o_write_valid); end
    recv_bit(nack, re);
    n_checks++; if (nack !== 1'b0) begin n_fail++; $display("FAIL ws_data_ack: got %b want 0", nack); end
    n_checks++; if (o_write_valid !== 1'b1) begin n_fail++; $display("FAIL ws_valid_hold: got %b want 1", o_write_valid); end
    ack_req_cnt++;
    wait_clk(8);
    n_checks++; if (o_write_valid !== 1'b0) begin n_fail++; $display("FAIL ws_valid_clear: got %b want 0", o_write_valid); end
    n_checks++; if (o_register_address !== 8'h56) begin n_fail++; $display("FAIL ws_addr_inc: got %h want 56", o_register_address); end
    bus_stop();
    model_mem[8'h55] = 8'hAA;
    auto_ack = 1'b1;
  endtask

  task automatic test_read_single();
    logic nack, re;
    logic [7:0] d;
    int rack0, n0;
    rack0 = rack_cycles;
    n0 = rd_addr_log.size();
    bus_start();
    send_byte(8'h66, nack);
    send_byte(8'hAA, nack);
    n_checks++; if (nack !== 1'b0) begin n_fail++; $display("FAIL rs_reg_ack: got %b want 0", nack); end
    bus_start();
    send_bits(8'h67);
    recv_bit(nack, re);
    n_checks++; if (nack !== 1'b0) begin n_fail++; $display("FAIL rs_addr_ack: got %b want 0", nack); end
    n_checks++; if (re !== 1'b1) begin n_fail++; $display("FAIL rs_enable_at_fall: got %b want 1", re); end
    recv_byte(d, 1'b0);
    n_checks++; if (d !== model_mem[8'hAA]) begin n_fail++; $display("FAIL rs_data: got %h want %h", d, model_mem[8'hAA]); end
    n_checks++; if (rack_cycles <= rack0) begin n_fail++; $display("FAIL rs_read_ack: got %0d cycles want >0", rack_cycles - rack0); end
    n_checks++; if (rd_addr_log.size() != n0 + 1 || rd_addr_log[n0] !== 8'hAA) begin
      n_fail++; $display("FAIL rs_window_addr: got %0d windows want 1 at AA", rd_addr_log.size() - n0); end
    bus_stop();
  endtask

  task automatic test_burst_write();
    logic nack;
    logic [7:0] d [4];
    int n0;
    d[0] = 8'hEF; d[1] = 8'hBE; d[2] = 8'hAD; d[3] = 8'hDE;
    n0 = wr_log.size();
    bus_start();
    send_byte(8'h66, nack);
    send_byte(8'h00, nack);
    for (int k = 0; k < 4; k++) begin
      send_byte(d[k], nack);
      n_checks++; if (nack !== 1'b0) begin n_fail++; $display("FAIL bw_ack%0d: got %b want 0", k, nack); end
      model_mem[k] = d[k];
    end
    bus_stop();
    wait_clk(8);
    n_checks++; if (wr_log.size() != n0 + 4) begin n_fail++; $display("FAIL bw_count: got %0d want 4", wr_log.size() - n0); end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (wr_log[n0+k] !== {8'(k), d[k]}) begin
        n_fail++; $display("FAIL bw_entry%0d: got %h want %h", k, wr_log[n0+k], {8'(k), d[k]}); end
    end
  endtask

  task automatic test_burst_read();
    logic nack;
    logic [7:0] d;
    int n0;
    n0 = rd_addr_log.size();
    bus_start();
    send_byte(8'h66, nack);
    send_byte(8'h10, nack);
    bus_start();
    send_byte(8'h67, nack);
    n_checks++; if (nack !== 1'b0) begin n_fail++; $display("FAIL br_addr_ack: got %b want 0", nack); end
    for (int k = 0; k < 4; k++) begin
      recv_byte(d, k != 3);
      n_checks++; if (d !== model_mem[8'h10 + k]) begin n_fail++; $display("FAIL br_data%0d: got %h want %h", k, d, model_mem[8'h10 + k]); end
    end
    bus_stop();
    n_checks++; if (rd_addr_log.size() != n0 + 4) begin n_fail++; $display("FAIL br_windows: got %0d want 4", rd_addr_log.size() - n0); end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (rd_addr_log[n0+k] !== 8'(8'h10 + k)) begin
        n_fail++; $display("FAIL br_addr%0d: got %h want %h", k, rd_addr_log[n0+k], 8'(8'h10 + k)); end
    end
  endtask

  task automatic test_wrong_address();
    logic nack;
    logic [7:0] d;
    int wv0, re0;
    wv0 = wv_cycles;
    re0 = re_cycles;
    bus_start();
    send_byte(8'h68, nack);
    n_checks++; if (nack !== 1'b1) begin n_fail++; $display("FAIL wa_write_nack: got %b want 1", nack); end
    send_byte(8'hC3, nack);
    n_checks++; if (nack !== 1'b1) begin n_fail++; $display("FAIL wa_ignore_nack: got %b want 1", nack); end
    bus_stop();
    bus_start();
    send_byte(8'h69, nack);
    n_checks++; if (nack !== 1'b1) begin n_fail++; $display("FAIL wa_read_nack: got %b want 1", nack); end
    recv_byte(d, 1'b0);
    n_checks++; if (d !== 8'hFF) begin n_fail++; $display("FAIL wa_bus_idle: got %h want FF", d); end
    bus_stop();
    n_checks++; if (wv_cycles != wv0 || re_cycles != re0) begin
      n_fail++; $display("FAIL wa_no_access: got wv=%0d re=%0d cycles want 0 0", wv_cycles - wv0, re_cycles - re0); end
  endtask

  task automatic test_random_bursts();
    logic nack;
    logic [7:0] base, a, rd;
    logic [7:0] d [5];
    int len, n0;
    for (int it = 0; it < 4; it++) begin
      base = (it == 0) ? 8'hFE : 8'($urandom);
      len = $urandom_range(2, 5);
      n0 = wr_log.size();
      bus_start();
      send_byte(8'h66, nack);
      send_byte(base, nack);
      for (int k = 0; k < len; k++) begin
        d[k] = 8'($urandom);
        send_byte(d[k], nack);
        n_checks++; if (nack !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_wack%0d: got %b want 0", it, k, nack); end
        a = base + 8'(k);
        model_mem[a] = d[k];
      end
      bus_stop();
      wait_clk(8);
      n_checks++; if (wr_log.size() != n0 + len) begin n_fail++; $display("FAIL rnd%0d_wcount: got %0d want %0d", it, wr_log.size() - n0, len); end
      for (int k = 0; k < len; k++) begin
        a = base + 8'(k);
        n_checks++; if (wr_log[n0+k] !== {a, d[k]}) begin
          n_fail++; $display("FAIL rnd%0d_wentry%0d: got %h want %h", it, k, wr_log[n0+k], {a, d[k]}); end
      end
      bus_start();
      send_byte(8'h66, nack);
      send_byte(base, nack);
      bus_start();
      send_byte(8'h67, nack);
      for (int k = 0; k < len; k++) begin
        recv_byte(rd, k != len - 1);
        a = base + 8'(k);
        n_checks++; if (rd !== model_mem[a]) begin n_fail++; $display("FAIL rnd%0d_rdata%0d: got %h want %h", it, k, rd, model_mem[a]); end
      end
      bus_stop();
    end
  endtask

  task automatic test_reset_midbyte();
    logic nack, bb, re;
    logic exp_low;
    bus_start();
    send_byte(8'h66, nack);
    send_byte(8'h12, nack);
    bus_start();
    send_byte(8'h67, nack);
    for (int i = 0; i < 3; i++) recv_bit(bb, re);
    exp_low = ~model_mem[8'h12][4];
    n_checks++; if ((sda_w === 1'b0) !== exp_low) begin n_fail++; $display("FAIL mr_tx_bit4: got low=%b want low=%b", sda_w === 1'b0, exp_low); end
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(1);
    n_checks++; if (o_register_address !== 8'h00 || o_register_data !== 8'h00) begin
      n_fail++; $display("FAIL mr_regs: got addr=%h data=%h want 00 00", o_register_address, o_register_data); end
    n_checks++; if (o_write_valid !== 1'b0 || o_read_enable !== 1'b0 || o_read_ack !== 1'b0) begin
      n_fail++; $display("FAIL mr_strobes: wv=%b re=%b rack=%b want 000", o_write_valid, o_read_enable, o_read_ack); end
    n_checks++; if (sda_w === 1'b0) begin n_fail++; $display("FAIL mr_sda: SDA held low, want released"); end
    bus_stop();
    bus_start();
    send_byte(8'h66, nack);
    n_checks++; if (nack !== 1'b0) begin n_fail++; $display("FAIL mr_addr_ack: got %b want 0", nack); end
    send_byte(8'h07, nack);
    send_byte(8'h5A, nack);
    n_checks++; if (nack !== 1'b0) begin n_fail++; $display("FAIL mr_data_ack: got %b want 0", nack); end
    bus_stop();
    wait_clk(8);
    model_mem[8'h07] = 8'h5A;
    n_checks++; if (wr_log.size() == 0 || wr_log[wr_log.size()-1] !== 16'h075A) begin
      n_fail++; $display("FAIL mr_write: got %h want 075A", (wr_log.size() == 0) ? 16'h0 : wr_log[wr_log.size()-1]); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    auto_ack = 1'b1; ack_req_cnt = 0;
    scl_m = 1'b1; sda_m_low = 1'b0; rst = 1'b1;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    model_mem[8'h10] = 8'hEF; model_mem[8'h11] = 8'hBE; model_mem[8'h12] = 8'hAD; model_mem[8'h13] = 8'hDE;
    model_mem[8'hAA] = 8'h55;
    test_reset();
    test_write_single();
    test_read_single();
    test_burst_write();
    test_burst_read();
    test_wrong_address();
    test_random_bursts();
    test_reset_midbyte();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
